// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes and arbiter state encoding.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam logic [OP_W-1:0] ALUOP_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALUOP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALUOP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALUOP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] ALUOP_LT  = 4'b0100;
  localparam logic [OP_W-1:0] ALUOP_XOR = 4'b0101;
  localparam logic [OP_W-1:0] ALUOP_SRL = 4'b1000;
  localparam logic [OP_W-1:0] ALUOP_SLL = 4'b1001;
  localparam logic [OP_W-1:0] ALUOP_SRA = 4'b1010;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU; undefined opcodes yield result 0 (zero flag set).
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);
  always_comb begin
    case (alu_op_i)
      ALUOP_AND: result_o = a_i & b_i;
      ALUOP_OR:  result_o = a_i | b_i;
      ALUOP_ADD: result_o = a_i + b_i;
      ALUOP_SUB: result_o = a_i - b_i;
      ALUOP_LT:  result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALUOP_XOR: result_o = a_i ^ b_i;
      ALUOP_SRL: result_o = a_i >> b_i[4:0];
      ALUOP_SLL: result_o = a_i << b_i[4:0];
      ALUOP_SRA: result_o = DATA_W'($signed(a_i) >>> b_i[4:0]);
      default:   result_o = '0;
    endcase
    zero_o = result_o == '0;
  end
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one ALU between two valid/ready requesters,
// operands latched at accept, registered response on a valid/ready channel.
module alu_rr_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req0_alu_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OP_W-1:0]   req1_alu_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              busy
);
  state_t            state_q, state_d;
  logic              last_grant_q, id_q, win, accept;
  logic [DATA_W-1:0] op1_q, op2_q, alu_res;
  logic [OP_W-1:0]   alu_op_q;
  logic              alu_zero;
  // Requester != last_grant wins a tie; a lone valid requester always wins.
  always_comb begin
    win        = state_q == IDLE || (state_q == RESP && resp_ready);
    req0_ready = win && req0_valid && (!req1_valid || last_grant_q);
    req1_ready = win && req1_valid && (!req0_valid || !last_grant_q);
    accept     = req0_ready || req1_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == EXEC ? RESP :
              accept ? EXEC :
              (state_q == RESP && !resp_ready) ? RESP : IDLE;
  always_comb begin
    resp_valid = state_q == RESP;
    busy       = state_q != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      alu_op_q     <= '0;
      resp_id      <= 1'b0;
      resp_result  <= '0;
      resp_zero    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_q <= req1_ready;
        id_q         <= req1_ready;
        op1_q        <= req1_ready ? req1_op1 : req0_op1;
        op2_q        <= req1_ready ? req1_op2 : req0_op2;
        alu_op_q     <= req1_ready ? req1_alu_op : req0_alu_op;
      end
      if (state_q == EXEC) begin
        resp_id     <= id_q;
        resp_result <= alu_res;
        resp_zero   <= alu_zero;
      end
    end
  alu u_alu (
    .alu_op_i (alu_op_q),
    .a_i      (op1_q),
    .b_i      (op2_q),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );
endmodule
